ne_dot_accum: RTL
=================

NE_DOT_ACCUM -- requirements
Module: ne_dot_accum

Interface
REQ-001 Parameter WIDTH, default 32: width of the carry-save input pair from the upstream 16-input CSA tree.
REQ-002 Parameter ACC_W, default 40: accumulator and result width, two's complement; ACC_W >= WIDTH+1.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  carry-save beat present.
REQ-006 in_ready  output  1  beat accepted when in_valid && in_ready at a clk edge.
REQ-007 in_sum  input  WIDTH  tree sum vector (OUT0 of the tree).
REQ-008 in_carry  input  WIDTH  tree carry vector (OUT1 of the tree).
REQ-009 in_last  input  1  beat is the final partial of the current dot product.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  result consumed when out_valid && out_ready at a clk edge.
REQ-012 out_data  output  ACC_W  accumulated dot-product result.
REQ-013 out_count  output  8  beats in this result, saturating at 255.
REQ-014 out_ovf  output  1  signed overflow occurred during this result.

Function
REQ-015 Stage P: an accepted beat SHALL load p_val = (in_sum + in_carry) mod 2^WIDTH, plus p_last, and set p_valid.
REQ-016 p_val SHALL be sign-extended to ACC_W before accumulation.
REQ-017 The FSM SHALL have states IDLE, ACC and DONE.
REQ-018 p_adv = p_valid && state != DONE; in_ready SHALL equal !p_valid || state != DONE.
REQ-019 On p_adv, acc SHALL become (state==IDLE ? 0 : acc) + sext(p_val), and count SHALL become (state==IDLE ? 1 : min(count+1, 255)).
REQ-020 On p_adv, the next state SHALL be DONE if p_last, else ACC; p_valid SHALL clear unless a new beat is accepted in the same cycle.
REQ-021 In DONE: out_valid=1, out_data=acc, out_count=count, out_ovf=ovf, all held stable until the handshake completes.
REQ-022 On the out handshake, the FSM SHALL go to IDLE; there is no same-cycle bypass of a pending P beat into the new result.
REQ-023 Latency: with no back-pressure, out_valid SHALL assert on the second clk edge after the in_last beat's handshake edge.
REQ-024 ovf SHALL set when a signed ACC_W overflow occurs during a p_adv addition, and SHALL stay set until the result is handed off.
REQ-025 out_valid SHALL be 0 in IDLE and ACC; out_data, out_count and out_ovf are don't-care unless out_valid=1.
REQ-026 Throughput: with no back-pressure, one beat per cycle.

Reset
REQ-027 rst SHALL clear p_valid, set state=IDLE, and zero acc, count and ovf, giving out_valid=0, out_data=0, out_count=0 and out_ovf=0.
REQ-028 rst asserted mid-vector or in DONE SHALL discard all partial and pending results; the first beat after reset starts a new result.

Configuration
REQ-029 Macro NE_DOT_ACCUM_SATURATE_EN, when defined: on overflow, acc SHALL clamp to +2^(ACC_W-1)-1 or -2^(ACC_W-1), matching the sign of the true sum.
REQ-030 When NE_DOT_ACCUM_SATURATE_EN is undefined: acc SHALL wrap mod 2^ACC_W; ovf is set identically in both builds.

Verification (WIDTH=32, ACC_W=40)
REQ-031 Beats (5,3), (10,0xFFFFFFFE), (0,7,last) -> out_data=23, out_count=3, out_ovf=0; out_valid at the 2nd edge after the last handshake.
REQ-032 Single beat (0x80000000,0,last) -> out_data=0xFF80000000, out_count=1.
REQ-033 Hold out_ready=0 for 5 cycles in DONE while the next vector streams in -> out_data stable, in_ready=0 once P holds a beat, no beat lost; next result is correct.
REQ-034 257 beats of (0x7FFFFFFF,0), last on the 257th -> out_ovf=1, out_count=255; out_data=0x807FFFFEFF without the macro, 0x7FFFFFFFFF with it.
REQ-035 Two beats (1,0), then rst for 1 cycle, then (1,1,last) -> out_data=2, out_count=1; out_valid=0 throughout reset.

Source files
------------

// File: rtl/ne_dot_accum_if.sv
// Handshake bundle for ne_dot_accum: carry-save input beats in, accumulated results out.
// The slave modport is the accumulator; the master modport is the upstream/downstream side.
interface ne_dot_accum_if #(
    parameter int WIDTH = 32,
    parameter int ACC_W = 40
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_sum;
    logic [WIDTH-1:0] in_carry;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic [7:0]       out_count;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_sum, in_carry, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_ovf
    );

    modport master (
        output in_valid, in_sum, in_carry, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_ovf
    );
endinterface

// File: rtl/ne_dot_accum.sv
// Dot-product accumulator: resolves carry-save beats (stage P) and sums them into a signed result.
// Optional build macro NE_DOT_ACCUM_SATURATE_EN clamps on overflow instead of wrapping.
module ne_dot_accum #(
    parameter int WIDTH = 32,
    parameter int ACC_W = 40
) (
    input  logic             clk,
    input  logic             rst,
    ne_dot_accum_if.slave    bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Signed overflow: operands agree in sign but the result does not.
    function automatic logic add_ovf(input logic [ACC_W-1:0] a,
                                     input logic [ACC_W-1:0] b,
                                     input logic [ACC_W-1:0] s);
        return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
    endfunction

    logic [1:0]       state_q, state_d;
    logic             p_valid_q, p_valid_d;
    logic [WIDTH-1:0] p_val_q, p_val_d;
    logic             p_last_q, p_last_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       count_q, count_d;
    logic             ovf_q, ovf_d;

    logic             in_ready_s, accept_s, p_adv_s, out_fire_s, add_ovf_s;
    logic [ACC_W-1:0] addend_s, acc_base_s, sum_s, acc_new_s;

    // Handshake qualifiers and the accumulate datapath.
    always_comb begin
        in_ready_s = !p_valid_q || (state_q != ST_DONE);
        accept_s   = bus.in_valid && in_ready_s;
        p_adv_s    = p_valid_q && (state_q != ST_DONE);
        out_fire_s = (state_q == ST_DONE) && bus.out_ready;
        addend_s   = {{(ACC_W-WIDTH){p_val_q[WIDTH-1]}}, p_val_q};
        acc_base_s = (state_q == ST_IDLE) ? {ACC_W{1'b0}} : acc_q;
        sum_s      = acc_base_s + addend_s;
        add_ovf_s  = add_ovf(acc_base_s, addend_s, sum_s);
`ifdef NE_DOT_ACCUM_SATURATE_EN
        if (add_ovf_s) begin
            acc_new_s = acc_base_s[ACC_W-1] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_new_s = sum_s;
        end
`else
        acc_new_s = sum_s;
`endif
    end

    // Next-state for stage P, the FSM and the accumulator registers.
    always_comb begin
        state_d   = state_q;
        p_valid_d = p_valid_q;
        p_val_d   = p_val_q;
        p_last_d  = p_last_q;
        acc_d     = acc_q;
        count_d   = count_q;
        ovf_d     = ovf_q;

        if (accept_s) begin
            p_valid_d = 1'b1;
            p_val_d   = bus.in_sum + bus.in_carry;
            p_last_d  = bus.in_last;
        end else if (p_adv_s) begin
            p_valid_d = 1'b0;
        end else begin
            p_valid_d = p_valid_q;
        end

        case (state_q)
            ST_IDLE, ST_ACC: begin
                if (p_adv_s) begin
                    acc_d   = acc_new_s;
                    ovf_d   = ((state_q == ST_IDLE) ? 1'b0 : ovf_q) | add_ovf_s;
                    if (state_q == ST_IDLE) begin
                        count_d = 8'd1;
                    end else begin
                        count_d = (count_q == 8'd255) ? 8'd255 : count_q + 8'd1;
                    end
                    state_d = p_last_q ? ST_DONE : ST_ACC;
                end else begin
                    state_d = state_q;
                end
            end
            ST_DONE: begin
                // A pending P beat waits here; it starts the next result from IDLE.
                if (out_fire_s) begin
                    state_d = ST_IDLE;
                    ovf_d   = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            p_valid_q <= 1'b0;
            p_val_q   <= {WIDTH{1'b0}};
            p_last_q  <= 1'b0;
            acc_q     <= {ACC_W{1'b0}};
            count_q   <= 8'd0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            p_valid_q <= p_valid_d;
            p_val_q   <= p_val_d;
            p_last_q  <= p_last_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_data  = acc_q;
    assign bus.out_count = count_q;
    assign bus.out_ovf   = ovf_q;
endmodule
